xbus_arbiter: RTL and testbench

Two-master round-robin arbiter for the simulation xbus slave port of the external configuration memory. It merges two requesters (e.g. the configuration loader and a debug/readback engine) onto one xbus slave interface. It issues each transfer as a single-cycle `xbs_select` pulse and waits for the slave's one-cycle `sl_ack`. It returns read data and acknowledge to the owning master, and aborts with an error if the slave never answers.

---
 rtl/xbus_arbiter_if.sv | 52 +++++
 rtl/xbus_arbiter.sv | 120 ++++++++++++
 tb/tb_xbus_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xbus_arbiter_if.sv
// Bus bundle for the two-master xbus arbiter: both requester channels, the xbus
// slave channel, and grant/status. 'master' is the arbiter's view, 'slave' the environment's.
interface xbus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_data;
  logic        m0_rnw;
  logic [3:0]  m0_be;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_data;
  logic        m1_rnw;
  logic [3:0]  m1_be;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] m1_rdata;

  logic        xbs_select;
  logic [31:0] xbs_addr;
  logic [31:0] xbs_data;
  logic        xbs_rnw;
  logic [3:0]  xbs_be;
  logic        sl_ack;
  logic [31:0] sl_data;

  logic [1:0]  gnt;
  logic        timeout_sticky;

  modport master (
    input  m0_req, m0_addr, m0_data, m0_rnw, m0_be,
    input  m1_req, m1_addr, m1_data, m1_rnw, m1_be,
    input  sl_ack, sl_data,
    output m0_ack, m0_err, m0_rdata,
    output m1_ack, m1_err, m1_rdata,
    output xbs_select, xbs_addr, xbs_data, xbs_rnw, xbs_be,
    output gnt, timeout_sticky
  );

  modport slave (
    output m0_req, m0_addr, m0_data, m0_rnw, m0_be,
    output m1_req, m1_addr, m1_data, m1_rnw, m1_be,
    output sl_ack, sl_data,
    input  m0_ack, m0_err, m0_rdata,
    input  m1_ack, m1_err, m1_rdata,
    input  xbs_select, xbs_addr, xbs_data, xbs_rnw, xbs_be,
    input  gnt, timeout_sticky
  );
endinterface

// File: rtl/xbus_arbiter.sv
// Two-master round-robin arbiter onto one xbus slave: single-cycle select,
// wait for the slave's ack, abort with an error after TIMEOUT silent cycles.
module xbus_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rstn,
  xbus_arbiter_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic          last;
  logic          owner;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    ack_q;
  logic [1:0]    err_q;
  logic [31:0]   rdata_q [2];

  logic [1:0]    req;
  logic          win;

  // On a tie the master that was not served last wins.
  always_comb begin
    req = {bus.m1_req, bus.m0_req};
    win = 1'b0;
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      last               <= 1'b1;
      owner              <= 1'b0;
      wait_cnt           <= '0;
      ack_q              <= '0;
      err_q              <= '0;
      // NOTE: the read-data "array" is only two registers and is a visible
      // output, so it is reset like any other flop (unlike a real RAM).
      rdata_q[0]         <= '0;
      rdata_q[1]         <= '0;
      bus.xbs_select     <= 1'b0;
      bus.xbs_addr       <= '0;
      bus.xbs_data       <= '0;
      bus.xbs_rnw        <= 1'b0;
      bus.xbs_be         <= '0;
      bus.gnt            <= '0;
      bus.timeout_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner          <= win;
            bus.gnt        <= win ? 2'b10 : 2'b01;
            bus.xbs_addr   <= win ? bus.m1_addr : bus.m0_addr;
            bus.xbs_data   <= win ? bus.m1_data : bus.m0_data;
            bus.xbs_rnw    <= win ? bus.m1_rnw  : bus.m0_rnw;
            bus.xbs_be     <= win ? bus.m1_be   : bus.m0_be;
            bus.xbs_select <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          bus.xbs_select <= 1'b0;
          wait_cnt       <= '0;
          state          <= WAIT;
        end

        WAIT: begin
          // An ack on the expiring edge still counts as a normal completion.
          if (bus.sl_ack) begin
            rdata_q[owner] <= bus.xbs_rnw ? bus.sl_data : 32'h0;
            ack_q[owner]   <= 1'b1;
            err_q[owner]   <= 1'b0;
            state          <= DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            wait_cnt           <= wait_cnt + CW'(1);
            rdata_q[owner]     <= 32'h0;
            ack_q[owner]       <= 1'b1;
            err_q[owner]       <= 1'b1;
            bus.timeout_sticky <= 1'b1;
            state              <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        DONE: begin
          ack_q   <= '0;
          err_q   <= '0;
          last    <= owner;
          bus.gnt <= '0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack   = ack_q[0];
  assign bus.m0_err   = err_q[0];
  assign bus.m0_rdata = rdata_q[0];
  assign bus.m1_ack   = ack_q[1];
  assign bus.m1_err   = err_q[1];
  assign bus.m1_rdata = rdata_q[1];

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter: command queues drive both masters, a
// latency-L slave model answers, and completions are scoreboarded against expectations.
module tb_xbus_arbiter;

  localparam int unsigned TIMEOUT = 8;
  localparam int          L       = 3;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rnw;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    int          m;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  gnt;
    int          cyc;
    int          sel_cyc;
  } obs_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  xbus_arbiter_if bus ();

  xbus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  cmd_t cmd_q0[$];
  cmd_t cmd_q1[$];
  exp_t exp_q[$];
  obs_t obs_q[$];

  int cyc       = 0;
  int sel_cyc   = 0;
  int n_sel     = 0;
  int sel_viol  = 0;
  int gnt_viol  = 0;
  bit prev_sel  = 1'b0;

  logic        slave_ack  = 1'b0;
  logic [31:0] slave_data = 32'h5A5A_5A5A;
  logic        stray_ack  = 1'b0;
  bit          mute       = 1'b0;
  logic [31:0] mem [logic [31:0]];

  assign bus.sl_ack  = slave_ack | stray_ack;
  assign bus.sl_data = slave_data;

  always @(posedge clk) cyc++;

  // Slave model: samples select, answers L edges later; writes land at select time.
  int          s_cnt  = 0;
  bit          s_pend = 1'b0;
  logic [31:0] s_addr;
  logic        s_rnw;
  always @(negedge clk) begin
    logic [31:0] w;
    if (slave_ack) begin
      slave_ack  = 1'b0;
      slave_data = 32'h5A5A_5A5A;
    end
    if (!rstn) begin
      s_pend = 1'b0;
    end else if (bus.xbs_select && !mute) begin
      s_pend = 1'b1;
      s_cnt  = L;
      s_addr = bus.xbs_addr;
      s_rnw  = bus.xbs_rnw;
      if (!bus.xbs_rnw) begin
        w = mem.exists(bus.xbs_addr) ? mem[bus.xbs_addr] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (bus.xbs_be[b]) w[8*b +: 8] = bus.xbs_data[8*b +: 8];
        mem[bus.xbs_addr] = w;
      end
    end else if (s_pend) begin
      s_cnt--;
      if (s_cnt == 0) begin
        slave_ack  = 1'b1;
        slave_data = s_rnw ? (mem.exists(s_addr) ? mem[s_addr] : 32'h0) : 32'hBAD0_BAD0;
        s_pend     = 1'b0;
      end
    end
  end

  // Master drivers plus completion monitor, all sampled mid-cycle.
  always @(negedge clk) begin
    cmd_t c;
    if (bus.xbs_select) begin
      if (prev_sel) sel_viol++;
      sel_cyc = cyc;
      n_sel++;
    end
    prev_sel = bus.xbs_select;
    if (bus.gnt == 2'b11) gnt_viol++;

    if (!rstn) begin
      bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_data = '0; bus.m0_rnw = 1'b0; bus.m0_be = '0;
      bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_data = '0; bus.m1_rnw = 1'b0; bus.m1_be = '0;
    end else begin
      if (bus.m0_ack) obs_q.push_back('{0, bus.m0_rdata, bus.m0_err, bus.gnt, cyc, sel_cyc});
      if (bus.m1_ack) obs_q.push_back('{1, bus.m1_rdata, bus.m1_err, bus.gnt, cyc, sel_cyc});

      if (bus.m0_ack) bus.m0_req = 1'b0;
      else if (!bus.m0_req && cmd_q0.size() > 0) begin
        c = cmd_q0.pop_front();
        bus.m0_addr = c.addr; bus.m0_data = c.data; bus.m0_rnw = c.rnw; bus.m0_be = c.be;
        bus.m0_req  = 1'b1;
      end

      if (bus.m1_ack) bus.m1_req = 1'b0;
      else if (!bus.m1_req && cmd_q1.size() > 0) begin
        c = cmd_q1.pop_front();
        bus.m1_addr = c.addr; bus.m1_data = c.data; bus.m1_rnw = c.rnw; bus.m1_be = c.be;
        bus.m1_req  = 1'b1;
      end
    end
  end

  task automatic post(input int m, input logic [31:0] addr, input logic [31:0] data,
                      input logic rnw, input logic [3:0] be,
                      input bit expect_done, input logic [31:0] exp_rdata, input logic exp_err);
    if (m == 0) cmd_q0.push_back('{addr, data, rnw, be});
    else        cmd_q1.push_back('{addr, data, rnw, be});
    if (expect_done) exp_q.push_back('{m, exp_rdata, exp_err});
  endtask

  task automatic wait_acks(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (bus.gnt !== 2'b00 || bus.xbs_select !== 1'b0) begin
      bad++; $display("FAIL reset_gnt_sel: gnt=%b sel=%b want 00 0", bus.gnt, bus.xbs_select);
    end
    total++;
    if ({bus.xbs_addr, bus.xbs_data, bus.xbs_rnw, bus.xbs_be} !== '0) begin
      bad++; $display("FAIL reset_xbs: addr=%h data=%h rnw=%b be=%h want all 0",
                      bus.xbs_addr, bus.xbs_data, bus.xbs_rnw, bus.xbs_be);
    end
    total++;
    if ({bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata} !== '0) begin
      bad++; $display("FAIL reset_master_outs: m0 %b%b %h m1 %b%b %h want all 0",
                      bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata);
    end
    total++;
    if (bus.timeout_sticky !== 1'b0) begin
      bad++; $display("FAIL reset_sticky: got %b want 0", bus.timeout_sticky);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_contention;
    bit   ok;
    obs_t r;
    exp_t e;
    int   prev_cyc;
    post(0, 32'h30, 32'h0, 1'b1, 4'hF, 1'b1, 32'h3030_3030, 1'b0);
    post(1, 32'h40, 32'h0, 1'b1, 4'hF, 1'b1, 32'h4040_4040, 1'b0);
    post(0, 32'h30, 32'h0, 1'b1, 4'hF, 1'b1, 32'h3030_3030, 1'b0);
    post(1, 32'h40, 32'h0, 1'b1, 4'hF, 1'b1, 32'h4040_4040, 1'b0);
    wait_acks(4, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL contention_done: got %0d acks want 4", obs_q.size());
    end else begin
      prev_cyc = 0;
      for (int i = 0; i < 4; i++) begin
        r = obs_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (r.m != e.m || r.rdata !== e.rdata || r.err !== e.err || r.gnt !== (2'b01 << e.m)) begin
          bad++; $display("FAIL contention_%0d: got m%0d rdata=%h err=%b gnt=%b want m%0d rdata=%h err=%b",
                          i, r.m, r.rdata, r.err, r.gnt, e.m, e.rdata, e.err);
        end
        if (i > 0) begin
          total++;
          if (r.cyc - prev_cyc != L + 3) begin
            bad++; $display("FAIL b2b_spacing_%0d: got %0d cycles want %0d", i, r.cyc - prev_cyc, L + 3);
          end
        end
        prev_cyc = r.cyc;
      end
    end
    total++;
    if (gnt_viol != 0 || sel_viol != 0) begin
      bad++; $display("FAIL contention_onehot: gnt_viol=%0d sel_viol=%0d want 0 0", gnt_viol, sel_viol);
    end
  endtask

  task automatic test_single_read;
    bit   ok;
    obs_t r;
    exp_t e;
    int   sel_before;
    sel_before = n_sel;
    post(0, 32'h10, 32'h0, 1'b1, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_acks(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_read_done: no ack, want one");
    end else begin
      r = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r.m != e.m || r.rdata !== e.rdata || r.err !== e.err) begin
        bad++; $display("FAIL single_read: got m%0d rdata=%h err=%b want m%0d rdata=%h err=%b",
                        r.m, r.rdata, r.err, e.m, e.rdata, e.err);
      end
      total++;
      if (r.cyc - r.sel_cyc != L + 1) begin
        bad++; $display("FAIL single_read_latency: got %0d want %0d", r.cyc - r.sel_cyc, L + 1);
      end
    end
    total++;
    if (n_sel - sel_before != 1 || sel_viol != 0) begin
      bad++; $display("FAIL single_read_select: pulses=%0d viol=%0d want 1 0", n_sel - sel_before, sel_viol);
    end
  endtask

  task automatic test_partial_write;
    bit   ok;
    obs_t r;
    exp_t e;
    post(1, 32'h20, 32'h1122_3344, 1'b0, 4'h5, 1'b1, 32'h0, 1'b0);
    post(1, 32'h20, 32'h0,         1'b1, 4'hF, 1'b1, 32'hAA22_CC44, 1'b0);
    wait_acks(2, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL partial_done: got %0d acks want 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        r = obs_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (r.m != e.m || r.rdata !== e.rdata || r.err !== e.err) begin
          bad++; $display("FAIL partial_%0d: got m%0d rdata=%h err=%b want m%0d rdata=%h err=%b",
                          i, r.m, r.rdata, r.err, e.m, e.rdata, e.err);
        end
      end
    end
    total++;
    if (bus.m0_rdata !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL m0_rdata_hold: got %h want deadbeef", bus.m0_rdata);
    end
  endtask

  task automatic test_timeout;
    bit   ok;
    obs_t r;
    exp_t e;
    total++;
    if (bus.timeout_sticky !== 1'b0) begin
      bad++; $display("FAIL sticky_before_timeout: got %b want 0", bus.timeout_sticky);
    end
    mute = 1'b1;
    post(0, 32'h10, 32'h0, 1'b1, 4'hF, 1'b1, 32'h0, 1'b1);
    wait_acks(1, ok);
    mute = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("FAIL timeout_done: no ack, want error ack");
    end else begin
      r = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r.m != e.m || r.rdata !== e.rdata || r.err !== e.err) begin
        bad++; $display("FAIL timeout_ack: got m%0d rdata=%h err=%b want m%0d rdata=%h err=%b",
                        r.m, r.rdata, r.err, e.m, e.rdata, e.err);
      end
      total++;
      if (r.cyc - r.sel_cyc != int'(TIMEOUT) + 1) begin
        bad++; $display("FAIL timeout_latency: got %0d want %0d", r.cyc - r.sel_cyc, TIMEOUT + 1);
      end
    end
    total++;
    if (bus.timeout_sticky !== 1'b1) begin
      bad++; $display("FAIL sticky_set: got %b want 1", bus.timeout_sticky);
    end
    post(1, 32'h40, 32'h0, 1'b1, 4'hF, 1'b1, 32'h4040_4040, 1'b0);
    wait_acks(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL after_timeout_done: no ack, want one");
    end else begin
      r = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r.m != e.m || r.rdata !== e.rdata || r.err !== e.err) begin
        bad++; $display("FAIL after_timeout: got m%0d rdata=%h err=%b want m%0d rdata=%h err=%b",
                        r.m, r.rdata, r.err, e.m, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    bit   ok;
    obs_t r;
    exp_t e;
    mute = 1'b1;
    post(0, 32'h10, 32'h0, 1'b1, 4'hF, 1'b0, 32'h0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    total++;
    if (bus.gnt !== 2'b01) begin
      bad++; $display("FAIL midwait_gnt: got %b want 01", bus.gnt);
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({bus.gnt, bus.xbs_select, bus.xbs_addr, bus.xbs_data, bus.xbs_rnw, bus.xbs_be,
         bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.m1_ack, bus.m1_err, bus.m1_rdata,
         bus.timeout_sticky} !== '0) begin
      bad++; $display("FAIL async_reset: gnt=%b xbs_addr=%h m0_rdata=%h m1_rdata=%h sticky=%b want all 0",
                      bus.gnt, bus.xbs_addr, bus.m0_rdata, bus.m1_rdata, bus.timeout_sticky);
    end
    repeat (2) @(negedge clk);
    mute = 1'b0;
    rstn = 1'b1;
    obs_q.delete();
    post(1, 32'h40, 32'h0, 1'b1, 4'hF, 1'b1, 32'h4040_4040, 1'b0);
    post(0, 32'h30, 32'h0, 1'b1, 4'hF, 1'b1, 32'h3030_3030, 1'b0);
    post(1, 32'h40, 32'h0, 1'b1, 4'hF, 1'b1, 32'h4040_4040, 1'b0);
    // Hold m0 back until m1's solo transfer is granted, then let them tie.
    cmd_q0.delete();
    wait_acks(1, ok);
    cmd_q0.push_back('{32'h30, 32'h0, 1'b1, 4'hF});
    wait_acks(3, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL post_reset_done: got %0d acks want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        r = obs_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (r.m != e.m || r.rdata !== e.rdata || r.err !== e.err) begin
          bad++; $display("FAIL post_reset_%0d: got m%0d rdata=%h err=%b want m%0d rdata=%h err=%b",
                          i, r.m, r.rdata, r.err, e.m, e.rdata, e.err);
        end
      end
    end
  endtask

  task automatic test_stray_ack;
    bit   ok;
    obs_t r;
    exp_t e;
    int   sel_before;
    sel_before = n_sel;
    @(posedge clk); #2;
    stray_ack = 1'b1;
    @(posedge clk); #2;
    stray_ack = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    total++;
    if (obs_q.size() != 0 || bus.gnt !== 2'b00 || n_sel != sel_before) begin
      bad++; $display("FAIL stray_ack: acks=%0d gnt=%b selects=%0d want 0 00 0",
                      obs_q.size(), bus.gnt, n_sel - sel_before);
    end
    post(0, 32'h10, 32'h0, 1'b1, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0);
    wait_acks(1, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL after_stray_done: no ack, want one");
    end else begin
      r = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (r.m != e.m || r.rdata !== e.rdata || r.err !== e.err) begin
        bad++; $display("FAIL after_stray: got m%0d rdata=%h err=%b want m%0d rdata=%h err=%b",
                        r.m, r.rdata, r.err, e.m, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    mem[32'h10] = 32'hDEAD_BEEF;
    mem[32'h20] = 32'hAABB_CCDD;
    mem[32'h30] = 32'h3030_3030;
    mem[32'h40] = 32'h4040_4040;
    test_reset();
    test_contention();
    test_single_read();
    test_partial_write();
    test_timeout();
    test_reset_mid_wait();
    test_stray_ack();
    total++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: expected left=%0d observed left=%0d want 0 0",
                      exp_q.size(), obs_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
